// File: rtl/conv_window_mac_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_mac_ctrl_if
// Brief    : Start/address/data/result bundle between the window sequencer,
//            the image and kernel buffers, and the output writer.
// Revision : 1.0
// ============================================================================
interface conv_window_mac_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int CADDR_W = 8,
    parameter int DATA_W  = 16
);
    logic                  Start;
    logic [ADDR_W-1:0]     RowBase;
    logic [ADDR_W-1:0]     ColBase;
    logic                  RdEn;
    logic [ADDR_W-1:0]     PixAddr;
    logic [CADDR_W-1:0]    CoefAddr;
    logic [DATA_W-1:0]     PixData;
    logic [DATA_W-1:0]     CoefData;
    logic                  Busy;
    logic [31:0]           ResultData;
    logic                  ResultValid;
    logic                  ResultReady;

    // Environment side: issues Start, serves the memories, consumes results.
    modport master (
        output Start, RowBase, ColBase, PixData, CoefData, ResultReady,
        input  RdEn, PixAddr, CoefAddr, Busy, ResultData, ResultValid
    );

    modport slave (
        input  Start, RowBase, ColBase, PixData, CoefData, ResultReady,
        output RdEn, PixAddr, CoefAddr, Busy, ResultData, ResultValid
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_mac_ctrl
// Brief    : Walks a KSIZE x KSIZE window, issues pixel/coefficient reads and
//            accumulates the signed products into a 32-bit valid/ready result.
// Revision : 1.0
// ============================================================================
module conv_window_mac_ctrl #(
    parameter int KSIZE   = 3,
    parameter int IMG_W   = 28,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int CADDR_W = 8
) (
    input  wire logic               Clk,
    input  wire logic               ResetN,
    conv_window_mac_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int                 c_CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [c_CNT_W-1:0] c_KLAST = c_CNT_W'(KSIZE - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_CNT_W-1:0]     r_row;
    logic [c_CNT_W-1:0]     r_col;
    logic [c_CNT_W-1:0]     w_row_nxt;
    logic [c_CNT_W-1:0]     w_col_nxt;
    logic [ADDR_W-1:0]      r_row_base;
    logic [ADDR_W-1:0]      r_col_base;
    logic [ADDR_W-1:0]      w_row_base_nxt;
    logic [ADDR_W-1:0]      w_col_base_nxt;

    logic                   r_rden;
    logic                   w_rden_nxt;
    logic                   r_busy;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_pipe_vld;
    logic                   w_clear;
    logic                   w_load_addr;

    logic [ADDR_W-1:0]      r_pix_addr;
    logic [ADDR_W-1:0]      w_pix_addr_nxt;
    logic [CADDR_W-1:0]     r_coef_addr;
    logic [CADDR_W-1:0]     w_coef_addr_nxt;

    logic [31:0]            r_sum;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [31:0]            w_prod_ext;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_row_base_nxt = r_row_base;
        w_col_base_nxt = r_col_base;
        w_rden_nxt     = 1'b0;
        w_valid_nxt    = 1'b0;
        w_clear        = 1'b0;
        w_load_addr    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    w_state_nxt    = S_ISSUE;
                    w_row_base_nxt = bus.RowBase;
                    w_col_base_nxt = bus.ColBase;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                    w_rden_nxt     = 1'b1;
                    w_clear        = 1'b1;
                    w_load_addr    = 1'b1;
                end
            end
            S_ISSUE: begin
                // r_row/r_col name the tap currently on the address bus.
                if ((r_row == c_KLAST) && (r_col == c_KLAST)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_rden_nxt  = 1'b1;
                    w_load_addr = 1'b1;
                    if (r_col == c_KLAST) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + c_ONE;
                    end else begin
                        w_col_nxt = r_col + c_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (r_pipe_vld) begin
                    w_state_nxt = S_HOLD;
                    w_valid_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                w_valid_nxt = 1'b1;
                if (bus.ResultReady) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Out-of-range windows wrap silently by truncation to the bus width.
        if (w_load_addr) begin
            w_pix_addr_nxt  = ADDR_W'((32'(w_row_base_nxt) + 32'(w_row_nxt)) * 32'(IMG_W)
                                      + 32'(w_col_base_nxt) + 32'(w_col_nxt));
            w_coef_addr_nxt = CADDR_W'(32'(w_row_nxt) * 32'(KSIZE) + 32'(w_col_nxt));
        end else begin
            w_pix_addr_nxt  = r_pix_addr;
            w_coef_addr_nxt = r_coef_addr;
        end
    end

    assign w_prod     = $signed(bus.PixData) * $signed(bus.CoefData);
    assign w_prod_ext = 32'(w_prod);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_row       <= '0;
            r_col       <= '0;
            r_row_base  <= '0;
            r_col_base  <= '0;
            r_rden      <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_pipe_vld  <= 1'b0;
            r_pix_addr  <= '0;
            r_coef_addr <= '0;
            r_sum       <= '0;
        end else begin
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_row_base  <= w_row_base_nxt;
            r_col_base  <= w_col_base_nxt;
            r_rden      <= w_rden_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_valid     <= w_valid_nxt;
            // Memory data arrives one edge after the read strobe.
            r_pipe_vld  <= r_rden;
            r_pix_addr  <= w_pix_addr_nxt;
            r_coef_addr <= w_coef_addr_nxt;
            if (w_clear) begin
                r_sum <= '0;
            end else if (r_pipe_vld) begin
                r_sum <= r_sum + w_prod_ext;
            end
        end
    end

    assign bus.RdEn        = r_rden;
    assign bus.PixAddr     = r_pix_addr;
    assign bus.CoefAddr    = r_coef_addr;
    assign bus.Busy        = r_busy;
    assign bus.ResultData  = r_sum;
    assign bus.ResultValid = r_valid;

endmodule
`default_nettype wire
